// File: rtl/regfile_pkg.sv
// Shared helpers for the scoreboarded register file: reset-value rule and popcount.
package regfile_pkg;

  function automatic logic [31:0] rf_reset_val(input int unsigned i, input int unsigned dw);
    if (dw >= 32) return i;
    return i & ((32'd1 << dw) - 32'd1);
  endfunction

  // Callers zero-extend their busy vector to 64 bits, which bounds NUM_REGS at 64.
  function automatic int unsigned rf_popcount(input logic [63:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 64; i++) cnt += int'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: entry lookup plus optional same-cycle commit bypass.
module regfile_sb_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 3,
  parameter int NUM_REGS = 8,
  parameter int TAG_W    = 2,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic [AW-1:0]              i_addr,
  input  logic [NUM_REGS*DATA_W-1:0] i_data_flat,
  input  logic [NUM_REGS-1:0]        i_busy,
  input  logic [NUM_REGS*TAG_W-1:0]  i_tag_flat,
  input  logic                       i_wr_en,
  input  logic [AW-1:0]              i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_wr_clr,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_busy,
  output logic [TAG_W-1:0]           o_tag
);

  logic w_hit;

  assign w_hit  = (BYPASS != 0) && i_wr_en && (i_wr_addr == i_addr);
  assign o_data = w_hit ? i_wr_data : i_data_flat[int'(i_addr)*DATA_W +: DATA_W];
  // A commit that will clear busy is shown as already cleared; issues never bypass.
  assign o_busy = i_busy[i_addr] & ~(w_hit & i_wr_clr);
  assign o_tag  = i_tag_flat[int'(i_addr)*TAG_W +: TAG_W];

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register busy/tag scoreboard, commit bypass and flush.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 3,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 3,
  parameter int TAG_W    = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int CW      = AW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  input  logic [TAG_W-1:0]         iss_tag,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic                     flush,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [NUM_RD*TAG_W-1:0]  rd_tag,
  output logic [CW-1:0]            busy_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              busy;
    logic [TAG_W-1:0]  tag;
  } rf_entry_t;

  rf_entry_t r_ent [NUM_REGS];
  rf_entry_t w_nxt [NUM_REGS];
  logic [CW-1:0]              r_busy_cnt;
  logic [NUM_REGS-1:0]        w_busy;
  logic [NUM_REGS-1:0]        w_nxt_busy;
  logic [NUM_REGS*DATA_W-1:0] w_data_flat;
  logic [NUM_REGS*TAG_W-1:0]  w_tag_flat;
  logic                       w_iss_eff;
  logic                       w_wr_clr;

  // Flush suppresses issue; a same-register issue overrides the commit's busy clear.
  assign w_iss_eff = iss_en & ~flush;
  assign w_wr_clr  = wr_en && r_ent[wr_addr].busy && (r_ent[wr_addr].tag == wr_tag)
                     && !(w_iss_eff && (iss_addr == wr_addr));

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) w_nxt[i] = r_ent[i];
    if (wr_en) w_nxt[wr_addr].data = wr_data;
    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) w_nxt[i].busy = 1'b0;
    end else begin
      if (w_wr_clr) w_nxt[wr_addr].busy = 1'b0;
      if (w_iss_eff) begin
        w_nxt[iss_addr].busy = 1'b1;
        w_nxt[iss_addr].tag  = iss_tag;
      end
    end
    for (int i = 0; i < NUM_REGS; i++) w_nxt_busy[i] = w_nxt[i].busy;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_data_flat[i*DATA_W +: DATA_W] = r_ent[i].data;
      w_tag_flat[i*TAG_W +: TAG_W]    = r_ent[i].tag;
      w_busy[i]                       = r_ent[i].busy;
    end
  end

  // busy_cnt is counted from the next-state vector so it lines up with busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_ent[i] <= '{data: DATA_W'(rf_reset_val(i, DATA_W)), busy: 1'b0, tag: '0};
      end
      r_busy_cnt <= '0;
    end else begin
      r_ent      <= w_nxt;
      r_busy_cnt <= CW'(rf_popcount(64'(w_nxt_busy)));
    end
  end

  assign busy_cnt = r_busy_cnt;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .TAG_W   (TAG_W),
      .BYPASS  (BYPASS),
      .AW      (AW)
    ) u_rdport (
      .i_addr     (rd_addr[k*AW +: AW]),
      .i_data_flat(w_data_flat),
      .i_busy     (w_busy),
      .i_tag_flat (w_tag_flat),
      .i_wr_en    (wr_en),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .i_wr_clr   (w_wr_clr),
      .o_data     (rd_data[k*DATA_W +: DATA_W]),
      .o_busy     (rd_busy[k]),
      .o_tag      (rd_tag[k*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one bypassing and one non-bypassing instance.
module tb_regfile_sb;
  localparam int DW = 3;
  localparam int NR = 8;
  localparam int ND = 3;
  localparam int TW = 2;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iss_en = 1'b0;
  logic [AW-1:0] iss_addr = '0;
  logic [TW-1:0] iss_tag = '0;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [TW-1:0] wr_tag = '0;
  logic flush = 1'b0;
  logic [ND*AW-1:0] rd_addr = '0;

  logic [ND*DW-1:0] rd_data, nb_data;
  logic [ND-1:0]    rd_busy, nb_busy;
  logic [ND*TW-1:0] rd_tag, nb_tag;
  logic [AW:0]      busy_cnt, nb_cnt;

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND), .TAG_W(TW), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tag(wr_tag), .flush(flush),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND), .TAG_W(TW), .BYPASS(0)) u_nbp (
    .clk(clk), .rst_n(rst_n), .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tag(wr_tag), .flush(flush),
    .rd_addr(rd_addr), .rd_data(nb_data), .rd_busy(nb_busy), .rd_tag(nb_tag),
    .busy_cnt(nb_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND*DW-1:0] d;
    logic [ND-1:0]    b;
    logic [ND*TW-1:0] t;
    logic [ND*DW-1:0] nd;
    logic [ND-1:0]    nb;
    logic [AW:0]      cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  logic [DW-1:0] m_data [NR];
  logic          m_busy [NR];
  logic [TW-1:0] m_tag  [NR];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int k = 0; k < ND; k++) begin
        chk("rd_data", k, 32'(rd_data[k*DW +: DW]), 32'(e.d[k*DW +: DW]));
        chk("rd_busy", k, 32'(rd_busy[k]), 32'(e.b[k]));
        chk("rd_tag", k, 32'(rd_tag[k*TW +: TW]), 32'(e.t[k*TW +: TW]));
        chk("nb_data", k, 32'(nb_data[k*DW +: DW]), 32'(e.nd[k*DW +: DW]));
        chk("nb_busy", k, 32'(nb_busy[k]), 32'(e.nb[k]));
      end
      chk("busy_cnt", 0, 32'(busy_cnt), 32'(e.cnt));
      chk("nb_cnt", 0, 32'(nb_cnt), 32'(e.cnt));
    end
  end

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin
      m_data[i] = DW'(i);
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  function automatic logic commit_clears();
    return wr_en && m_busy[wr_addr] && (m_tag[wr_addr] == wr_tag)
           && !(iss_en && !flush && (iss_addr == wr_addr));
  endfunction

  task automatic push_exp();
    exp_t x;
    int n;
    logic clr;
    clr = commit_clears();
    n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    for (int k = 0; k < ND; k++) begin
      logic [AW-1:0] a;
      logic hit;
      a = rd_addr[k*AW +: AW];
      hit = wr_en && (wr_addr == a);
      x.d[k*DW +: DW]  = hit ? wr_data : m_data[a];
      x.b[k]           = (hit && clr) ? 1'b0 : m_busy[a];
      x.t[k*TW +: TW]  = m_tag[a];
      x.nd[k*DW +: DW] = m_data[a];
      x.nb[k]          = m_busy[a];
    end
    x.cnt = (AW+1)'(n);
    sb_q.push_back(x);
  endtask

  task automatic m_step();
    logic clr;
    clr = commit_clears();
    if (wr_en) m_data[wr_addr] = wr_data;
    if (flush) begin
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    end else begin
      if (clr) m_busy[wr_addr] = 1'b0;
      if (iss_en) begin
        m_busy[iss_addr] = 1'b1;
        m_tag[iss_addr]  = iss_tag;
      end
    end
  endtask

  function automatic logic [ND*AW-1:0] ra(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic cycle(input int ie, input int ia, input int it, input int we, input int wa,
                       input int wd, input int wt, input int fl, input logic [ND*AW-1:0] rda);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    iss_en   = (ie != 0);
    iss_addr = AW'(ia);
    iss_tag  = TW'(it);
    wr_en    = (we != 0);
    wr_addr  = AW'(wa);
    wr_data  = DW'(wd);
    wr_tag   = TW'(wt);
    flush    = (fl != 0);
    rd_addr  = rda;
    push_exp();
    m_step();
  endtask

  task automatic rst_cycle(input logic [ND*AW-1:0] rda);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    iss_en  = 1'b0;
    wr_en   = 1'b0;
    flush   = 1'b0;
    rd_addr = rda;
    m_reset();
    push_exp();
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    // Reset defaults
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ra(0, 1, 2));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ra(3, 4, 5));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ra(6, 7, 0));
    // Issue then matching commit
    cycle(1, 3, 2, 0, 0, 0, 0, 0, ra(3, 3, 0));
    cycle(0, 0, 0, 1, 3, 5, 2, 0, ra(3, 2, 1));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ra(3, 3, 3));
    // Stale commit leaves busy and the newer tag
    cycle(1, 4, 1, 0, 0, 0, 0, 0, ra(4, 0, 0));
    cycle(1, 4, 3, 0, 0, 0, 0, 0, ra(4, 0, 0));
    cycle(0, 0, 0, 1, 4, 2, 1, 0, ra(4, 4, 1));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ra(4, 4, 4));
    // Same-cycle issue and commit to one register
    cycle(1, 2, 0, 1, 2, 6, 0, 0, ra(2, 1, 0));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ra(2, 2, 2));
    // Bypass vs no bypass
    cycle(0, 0, 0, 1, 1, 7, 0, 0, ra(1, 0, 1));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ra(1, 1, 1));
    // Fill r0..r5, then flush with a concurrent issue of r6
    for (int i = 0; i < 6; i++) cycle(1, i, i % 4, 0, 0, 0, 0, 0, ra(i, 6, 0));
    cycle(1, 6, 1, 0, 0, 0, 0, 1, ra(6, 0, 5));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ra(6, 0, 5));
    // Reset in the middle of activity
    cycle(1, 7, 3, 1, 1, 4, 0, 0, ra(7, 1, 2));
    cycle(1, 5, 2, 0, 0, 0, 0, 0, ra(5, 7, 3));
    rst_cycle(ra(5, 7, 1));
    rst_cycle(ra(2, 3, 4));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, ra(5, 7, 1));
    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int wa;
      int wt;
      if (n == 200) begin
        rst_cycle(ra($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
      end
      wa = $urandom_range(0, 7);
      wt = ($urandom_range(0, 1) == 1) ? int'(m_tag[wa]) : $urandom_range(0, 3);
      cycle($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 1), wa, $urandom_range(0, 7), wt,
            ($urandom_range(0, 15) == 0) ? 1 : 0,
            ra(($urandom_range(0, 1) == 1) ? wa : $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7)));
    end
    repeat (3) @(posedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
